cpu_trace_buffer: RTL and testbench



---
 rtl/cpu_trace_buffer_if.sv | 36 +++
 rtl/cpu_trace_buffer.sv | 186 ++++++++++++++++++
 tb/tb_cpu_trace_buffer.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_trace_buffer_if.sv
// cpu_trace_buffer_if: capture-side and read-out signals of the trace buffer.
// master drives the CPU samples and read index; slave is the buffer itself.
interface cpu_trace_buffer_if #(
  parameter int DEPTH_LOG2 = 4
);
  logic                  iClockDIV;
  logic [31:0]           iPC;
  logic [31:0]           iInstr;
  logic [4:0]            iRd;
  logic [31:0]           iEscritaReg;
  logic                  iTrigEn;
  logic [31:0]           iTrigPC;
  logic                  iRearm;
  logic [DEPTH_LOG2-1:0] iRdIdx;
  logic [31:0]           oRdPC;
  logic [31:0]           oRdInstr;
  logic [31:0]           oRdWb;
  logic [4:0]            oRdRd;
  logic [DEPTH_LOG2:0]   oCount;
  logic [1:0]            oState;
  logic                  oTriggered;

  modport master (
    output iClockDIV, iPC, iInstr, iRd, iEscritaReg,
    output iTrigEn, iTrigPC, iRearm, iRdIdx,
    input  oRdPC, oRdInstr, oRdWb, oRdRd,
    input  oCount, oState, oTriggered
  );

  modport slave (
    input  iClockDIV, iPC, iInstr, iRd, iEscritaReg,
    input  iTrigEn, iTrigPC, iRearm, iRdIdx,
    output oRdPC, oRdInstr, oRdWb, oRdRd,
    output oCount, oState, oTriggered
  );
endinterface

// File: rtl/cpu_trace_buffer.sv
// cpu_trace_buffer: circular capture of committed CPU state with PC trigger.
// Define TRACE_WB_EN to also store and read back rd index and write-back data.
module cpu_trace_buffer #(
  parameter int DEPTH_LOG2 = 4,
  parameter int POST_TRIG  = 4
) (
  input  logic                  CLOCK,
  input  logic                  Reset,
  cpu_trace_buffer_if.slave     bus
);

  localparam int N = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL  = (DEPTH_LOG2+1)'(N);
  localparam logic [DEPTH_LOG2:0]   ONE_C = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] ONE_P = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2-1:0] PT    = DEPTH_LOG2'(POST_TRIG);

  typedef enum logic [1:0] {
    CAPTURE = 2'd0,
    POST    = 2'd1,
    FROZEN  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [DEPTH_LOG2-1:0] post_q, post_d;
  logic                  trig_q, trig_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q;
  logic [DEPTH_LOG2:0]   count_q;
  logic                  clkdiv_q;

  logic                  strobe;
  logic                  hit;
  logic                  store;

  logic [31:0] mem_pc [N];
  logic [31:0] mem_in [N];

  logic [DEPTH_LOG2:0]   rd_sum;
  logic [DEPTH_LOG2-1:0] rd_addr;
  logic                  rd_hit;
  logic [31:0]           rd_pc_q;
  logic [31:0]           rd_in_q;

  // Falling edge of the divided clock marks mid-period, stable CPU signals.
  assign strobe = clkdiv_q & ~bus.iClockDIV;
  assign hit    = bus.iTrigEn & (bus.iPC == bus.iTrigPC);
  assign store  = strobe & ~bus.iRearm & (state_q != FROZEN);

  // Divider history; starts high so a low divider out of reset strobes.
  always_ff @(posedge CLOCK) begin
    if (Reset) clkdiv_q <= 1'b1;
    else       clkdiv_q <= bus.iClockDIV;
  end

  // Capture state machine registers.
  always_ff @(posedge CLOCK) begin
    if (Reset) begin
      state_q <= CAPTURE;
      post_q  <= '0;
      trig_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      post_q  <= post_d;
      trig_q  <= trig_d;
    end
  end

  // Next state: rearm dominates, trigger only armed while capturing.
  always_comb begin
    state_d = state_q;
    post_d  = post_q;
    trig_d  = trig_q;
    if (bus.iRearm) begin
      state_d = CAPTURE;
      post_d  = '0;
      trig_d  = 1'b0;
    end else if (strobe) begin
      unique case (state_q)
        CAPTURE: begin
          if (hit) begin
            trig_d = 1'b1;
            if (POST_TRIG == 0) begin
              state_d = FROZEN;
            end else begin
              state_d = POST;
              post_d  = PT;
            end
          end
        end
        POST: begin
          post_d = post_q - ONE_P;
          if (post_q == ONE_P) state_d = FROZEN;
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  // Write pointer and saturating occupancy; rearm empties the buffer.
  always_ff @(posedge CLOCK) begin
    if (Reset) begin
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (bus.iRearm) begin
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (store) begin
      wr_ptr_q <= wr_ptr_q + ONE_P;
      if (count_q != FULL) count_q <= count_q + ONE_C;
    end
  end

  // Entry storage for PC and instruction word.
  always_ff @(posedge CLOCK) begin
    if (store) begin
      mem_pc[wr_ptr_q] <= bus.iPC;
      mem_in[wr_ptr_q] <= bus.iInstr;
    end
  end

  // Index 0 is the oldest entry; subtraction wraps in DEPTH_LOG2+1 bits.
  assign rd_sum  = {1'b0, wr_ptr_q} - count_q + {1'b0, bus.iRdIdx};
  assign rd_addr = rd_sum[DEPTH_LOG2-1:0];
  assign rd_hit  = {1'b0, bus.iRdIdx} < count_q;

  // Registered read-out; indices beyond the occupancy read as zero.
  always_ff @(posedge CLOCK) begin
    if (Reset) begin
      rd_pc_q <= '0;
      rd_in_q <= '0;
    end else if (rd_hit) begin
      rd_pc_q <= mem_pc[rd_addr];
      rd_in_q <= mem_in[rd_addr];
    end else begin
      rd_pc_q <= '0;
      rd_in_q <= '0;
    end
  end

`ifdef TRACE_WB_EN
  logic [4:0]  mem_rd [N];
  logic [31:0] mem_wb [N];
  logic [4:0]  rd_rd_q;
  logic [31:0] rd_wb_q;

  // Write-back fields stored alongside each entry.
  always_ff @(posedge CLOCK) begin
    if (store) begin
      mem_rd[wr_ptr_q] <= bus.iRd;
      mem_wb[wr_ptr_q] <= bus.iEscritaReg;
    end
  end

  // Registered read-out of write-back fields.
  always_ff @(posedge CLOCK) begin
    if (Reset) begin
      rd_rd_q <= '0;
      rd_wb_q <= '0;
    end else if (rd_hit) begin
      rd_rd_q <= mem_rd[rd_addr];
      rd_wb_q <= mem_wb[rd_addr];
    end else begin
      rd_rd_q <= '0;
      rd_wb_q <= '0;
    end
  end

  assign bus.oRdRd = rd_rd_q;
  assign bus.oRdWb = rd_wb_q;
`else
  logic unused_wb;

  assign unused_wb  = ^{bus.iRd, bus.iEscritaReg};
  assign bus.oRdRd  = '0;
  assign bus.oRdWb  = '0;
`endif

  assign bus.oRdPC      = rd_pc_q;
  assign bus.oRdInstr   = rd_in_q;
  assign bus.oCount     = count_q;
  assign bus.oState     = state_q;
  assign bus.oTriggered = trig_q;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// tb_cpu_trace_buffer: two buffers (post window 4 and 0) on shared stimulus,
// compared against a queue-based model of the capture rules.
module tb_cpu_trace_buffer;

  localparam int DL = 4;
  localparam int N  = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          div;
  logic [31:0]   pc, instr, wb, tpc;
  logic [4:0]    rd;
  logic          trig_en, rearm;
  logic [DL-1:0] idx;

  always #5 clk = ~clk;

  cpu_trace_buffer_if #(.DEPTH_LOG2(DL)) ia ();
  cpu_trace_buffer_if #(.DEPTH_LOG2(DL)) ib ();

  assign ia.iClockDIV   = div;
  assign ia.iPC         = pc;
  assign ia.iInstr      = instr;
  assign ia.iRd         = rd;
  assign ia.iEscritaReg = wb;
  assign ia.iTrigEn     = trig_en;
  assign ia.iTrigPC     = tpc;
  assign ia.iRearm      = rearm;
  assign ia.iRdIdx      = idx;
  assign ib.iClockDIV   = div;
  assign ib.iPC         = pc;
  assign ib.iInstr      = instr;
  assign ib.iRd         = rd;
  assign ib.iEscritaReg = wb;
  assign ib.iTrigEn     = trig_en;
  assign ib.iTrigPC     = tpc;
  assign ib.iRearm      = rearm;
  assign ib.iRdIdx      = idx;

  cpu_trace_buffer #(.DEPTH_LOG2(DL), .POST_TRIG(4)) dut_a (
    .CLOCK (clk),
    .Reset (rst),
    .bus   (ia)
  );

  cpu_trace_buffer #(.DEPTH_LOG2(DL), .POST_TRIG(0)) dut_b (
    .CLOCK (clk),
    .Reset (rst),
    .bus   (ib)
  );

  logic [31:0] o_pc [2];
  logic [31:0] o_in [2];
  logic [31:0] o_wb [2];
  logic [31:0] o_rd [2];
  logic [31:0] o_cnt [2];
  logic [31:0] o_st [2];
  logic [31:0] o_tr [2];

  assign o_pc[0]  = ia.oRdPC;
  assign o_in[0]  = ia.oRdInstr;
  assign o_wb[0]  = ia.oRdWb;
  assign o_rd[0]  = 32'(ia.oRdRd);
  assign o_cnt[0] = 32'(ia.oCount);
  assign o_st[0]  = 32'(ia.oState);
  assign o_tr[0]  = 32'(ia.oTriggered);
  assign o_pc[1]  = ib.oRdPC;
  assign o_in[1]  = ib.oRdInstr;
  assign o_wb[1]  = ib.oRdWb;
  assign o_rd[1]  = 32'(ib.oRdRd);
  assign o_cnt[1] = 32'(ib.oCount);
  assign o_st[1]  = 32'(ib.oState);
  assign o_tr[1]  = 32'(ib.oTriggered);

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] wb;
    logic [4:0]  rd;
  } ent_t;

  ent_t mq [2][$];
  int   mst [2];
  int   mtrig [2];
  int   mpost [2];
  int   ptrig [2] = '{4, 0};

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic model_clear();
    for (int m = 0; m < 2; m++) begin
      mq[m].delete();
      mst[m]   = 0;
      mtrig[m] = 0;
      mpost[m] = 0;
    end
  endtask

  task automatic model_strobe();
    ent_t e;
    e.pc    = pc;
    e.instr = instr;
    e.wb    = wb;
    e.rd    = rd;
    for (int m = 0; m < 2; m++) begin
      if (mst[m] != 2) begin
        mq[m].push_back(e);
        if (mq[m].size() > N) void'(mq[m].pop_front());
        if (mst[m] == 0) begin
          if (trig_en && pc == tpc) begin
            mtrig[m] = 1;
            if (ptrig[m] == 0) mst[m] = 2;
            else begin
              mst[m]   = 1;
              mpost[m] = ptrig[m];
            end
          end
        end else begin
          mpost[m]--;
          if (mpost[m] == 0) mst[m] = 2;
        end
      end
    end
  endtask

  task automatic strobe(input logic [31:0] p);
    pc    = p;
    instr = $urandom;
    wb    = $urandom;
    rd    = 5'($urandom);
    div   = 1'b0;
    cyc();
    model_strobe();
    repeat (3) cyc();
    div = 1'b1;
    repeat (4) cyc();
  endtask

  task automatic do_rearm();
    rearm = 1'b1;
    cyc();
    rearm = 1'b0;
    model_clear();
    cyc();
  endtask

  task automatic check_status(input string tag);
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("%s_cnt%0d", tag, m), o_cnt[m], 32'(mq[m].size()));
      chk($sformatf("%s_st%0d", tag, m), o_st[m], 32'(mst[m]));
      chk($sformatf("%s_trg%0d", tag, m), o_tr[m], 32'(mtrig[m]));
    end
  endtask

  task automatic check_read(input string tag, input int i);
    logic [31:0] epc, ein, ewb, erd;
    idx = DL'(i);
    cyc();
    for (int m = 0; m < 2; m++) begin
      epc = '0;
      ein = '0;
      ewb = '0;
      erd = '0;
      if (i < mq[m].size()) begin
        epc = mq[m][i].pc;
        ein = mq[m][i].instr;
`ifdef TRACE_WB_EN
        ewb = mq[m][i].wb;
        erd = 32'(mq[m][i].rd);
`endif
      end
      chk($sformatf("%s_pc%0d_i%0d", tag, m, i), o_pc[m], epc);
      chk($sformatf("%s_in%0d_i%0d", tag, m, i), o_in[m], ein);
      chk($sformatf("%s_wb%0d_i%0d", tag, m, i), o_wb[m], ewb);
      chk($sformatf("%s_rd%0d_i%0d", tag, m, i), o_rd[m], erd);
    end
  endtask

  initial begin
    rst     = 1'b1;
    div     = 1'b1;
    pc      = '0;
    instr   = '0;
    wb      = '0;
    rd      = '0;
    tpc     = '0;
    trig_en = 1'b0;
    rearm   = 1'b0;
    idx     = '0;
    model_clear();
    repeat (3) cyc();
    rst = 1'b0;
    cyc();

    check_status("reset");
    chk("reset_pc", o_pc[0], 32'h0);
    chk("reset_wb", o_wb[0], 32'h0);

    for (int i = 0; i < 5; i++) strobe(32'(i * 4));
    chk("five_cnt", o_cnt[0], 32'd5);
    chk("five_st", o_st[0], 32'd0);
    check_status("five");
    check_read("five", 0);
    chk("five_idx0", o_pc[0], 32'h0);
    check_read("five", 4);
    chk("five_idx4", o_pc[0], 32'h10);
    check_read("five_empty", 5);

    for (int i = 5; i < 20; i++) strobe(32'(i * 4));
    chk("wrap_cnt", o_cnt[0], 32'd16);
    check_status("wrap");
    check_read("wrap", 0);
    chk("wrap_idx0", o_pc[0], 32'h10);
    check_read("wrap", 15);
    chk("wrap_idx15", o_pc[0], 32'h4C);

    do_rearm();
    check_status("rearm");
    trig_en = 1'b1;
    tpc     = 32'h8;
    rd      = 5'd5;
    for (int i = 0; i < 10; i++) strobe(32'(i * 4));
    check_status("trig8");
    chk("trig8_st_b", o_st[1], 32'd2);
    check_read("trig8", 2);
    chk("trig8_last_b", o_pc[1], 32'h8);
    check_read("trig8", 6);
    chk("trig8_last_a", o_pc[0], 32'h18);

    do_rearm();
    tpc = 32'h20;
    for (int i = 0; i < 17; i++) strobe(32'(i * 4));
    check_status("trig20");
    chk("trig20_cnt_a", o_cnt[0], 32'd13);
    chk("trig20_st_a", o_st[0], 32'd2);
    chk("trig20_trg_a", o_tr[0], 32'd1);
    check_read("trig20", 12);
    chk("trig20_last_a", o_pc[0], 32'h30);

    pc    = 32'h200;
    div   = 1'b0;
    rearm = 1'b1;
    cyc();
    rearm = 1'b0;
    model_clear();
    repeat (3) cyc();
    div = 1'b1;
    repeat (4) cyc();
    check_status("rearm_strobe");
    chk("rearm_strobe_cnt", o_cnt[0], 32'd0);
    strobe(32'h100);
    chk("after_rearm_cnt", o_cnt[0], 32'd1);
    check_status("after_rearm");

    do_rearm();
    tpc = 32'h100;
    strobe(32'hFC);
    strobe(32'h100);
    strobe(32'h104);
    check_status("mid_post");
    chk("mid_post_st_a", o_st[0], 32'd1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    model_clear();
    cyc();
    check_status("post_reset");
    check_read("post_reset", 0);

    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 19) == 0) begin
        do_rearm();
      end else begin
        trig_en = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 7) == 0) tpc = 32'(4 * $urandom_range(0, 15));
        strobe(32'(4 * $urandom_range(0, 15)));
      end
      check_status($sformatf("rnd%0d", k));
      check_read($sformatf("rnd%0d", k), int'($urandom_range(0, N - 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
